// File: rtl/usb_dfu_flash_seq.sv
// DFU download sequencer: splits one buffered DNLOAD block into sector-erase and page-program
// commands for usb_spiflash_bridge and tracks bState/bStatus. Define USB_DFU_VERIFY_EN for a verify pass.
module usb_dfu_flash_seq #(
  parameter int ADDR_W = 24,
  parameter logic [ADDR_W-1:0] BASE_ADDR = 24'h100000,
  parameter int XFER_BITS = 8,
  parameter int PAGE_BITS = 8,
  parameter int SECTOR_BITS = 12,
  parameter int MAX_BLOCKS = 4096
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 dnload_start,
  input  logic [15:0]          dnload_block,
  input  logic [XFER_BITS:0]   dnload_len,
  input  logic                 abort,
  output logic                 busy,
  output logic [3:0]           dfu_state,
  output logic [3:0]           dfu_status,
  output logic                 flash_req,
  output logic [1:0]           flash_cmd,
  output logic [ADDR_W-1:0]    flash_addr,
  output logic [PAGE_BITS:0]   flash_len,
  output logic [XFER_BITS-1:0] buf_offset,
  input  logic                 flash_ack,
  input  logic                 flash_done,
  input  logic                 flash_err
);

  // state       | meaning
  // IDLE        | no work; dfu_state shows idle_code (dfuIDLE or dfuDNLOAD_IDLE)
  // CHECK       | range-check the latched block, choose erase or program
  // *_REQ/*_WAIT| command offered to the bridge / waiting for its done pulse
  // ADVANCE     | step past the finished chunk
  // MANIFEST    | one cycle of dfuMANIFEST after a zero-length block
  // ERROR       | dfuERROR, held until abort
  localparam logic [3:0] IDLE        = 4'd0;
  localparam logic [3:0] CHECK       = 4'd1;
  localparam logic [3:0] ERASE_REQ   = 4'd2;
  localparam logic [3:0] ERASE_WAIT  = 4'd3;
  localparam logic [3:0] PROG_REQ    = 4'd4;
  localparam logic [3:0] PROG_WAIT   = 4'd5;
`ifdef USB_DFU_VERIFY_EN
  localparam logic [3:0] VERIFY_REQ  = 4'd6;
  localparam logic [3:0] VERIFY_WAIT = 4'd7;
  localparam logic [3:0] PROG_OK     = VERIFY_REQ;
`endif
  localparam logic [3:0] ADVANCE     = 4'd8;
  localparam logic [3:0] MANIFEST    = 4'd9;
  localparam logic [3:0] ERROR       = 4'd10;
`ifndef USB_DFU_VERIFY_EN
  localparam logic [3:0] PROG_OK     = ADVANCE;
`endif

  localparam int LW = XFER_BITS + 1;
  localparam logic [PAGE_BITS:0] PAGE_SIZE = {1'b1, {PAGE_BITS{1'b0}}};
  localparam logic [XFER_BITS:0] XFER_SIZE = {1'b1, {XFER_BITS{1'b0}}};
  localparam logic [16:0] MAX_B = 17'(MAX_BLOCKS);

  logic [3:0]           state, ok_next, err_code, idle_code;
  logic [ADDR_W-1:0]    cur_addr, blk_addr;
  logic [XFER_BITS:0]   remaining, rem_next;
  logic [XFER_BITS-1:0] offset;
  logic [15:0]          blk;
  logic                 aborting, done_pend, err_pend;
  logic                 is_req, is_wait, cmd_done, cmd_err;
  logic [PAGE_BITS:0]   page_room, chunk;

  assign blk_addr  = ADDR_W'(dnload_block) << XFER_BITS;
  // A program chunk never runs past the end of the current flash page.
  assign page_room = PAGE_SIZE - {1'b0, cur_addr[PAGE_BITS-1:0]};
  assign chunk     = (remaining < LW'(page_room)) ? remaining[PAGE_BITS:0] : page_room;
  assign rem_next  = remaining - LW'(chunk);
  assign cmd_done  = done_pend | flash_done;
  assign cmd_err   = done_pend ? err_pend : flash_err;

  assign flash_addr = cur_addr;
  assign buf_offset = offset;

  always_comb begin
    is_req    = 1'b0;
    is_wait   = 1'b0;
    ok_next   = ADVANCE;
    err_code  = 4'd6;
    flash_req = 1'b0;
    flash_cmd = 2'b00;
    flash_len = '0;
    busy      = 1'b1;
    dfu_state = 4'd4;
    case (state)
      IDLE:       begin busy = 1'b0; dfu_state = idle_code; end
      ERROR:      begin busy = 1'b0; dfu_state = 4'd10; end
      MANIFEST:   dfu_state = 4'd7;
      ERASE_REQ:  begin is_req = 1'b1; flash_req = 1'b1; flash_cmd = 2'b01; end
      ERASE_WAIT: begin is_wait = 1'b1; flash_cmd = 2'b01; ok_next = PROG_REQ; err_code = 4'd4; end
      PROG_REQ:   begin is_req = 1'b1; flash_req = 1'b1; flash_cmd = 2'b10; flash_len = chunk; end
      PROG_WAIT:  begin is_wait = 1'b1; flash_cmd = 2'b10; flash_len = chunk; ok_next = PROG_OK; end
`ifdef USB_DFU_VERIFY_EN
      VERIFY_REQ: begin is_req = 1'b1; flash_req = 1'b1; flash_cmd = 2'b11; flash_len = chunk; end
      VERIFY_WAIT: begin
        is_wait = 1'b1; flash_cmd = 2'b11; flash_len = chunk; err_code = 4'd7;
      end
`endif
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      cur_addr   <= '0;
      remaining  <= '0;
      offset     <= '0;
      blk        <= '0;
      aborting   <= 1'b0;
      done_pend  <= 1'b0;
      err_pend   <= 1'b0;
      idle_code  <= 4'd2;
      dfu_status <= 4'd0;
    end else begin
      case (state)
        IDLE: begin
          if (abort) begin
            idle_code  <= 4'd2;
            dfu_status <= 4'd0;
          end else if (dnload_start && dnload_len == '0) begin
            state     <= MANIFEST;
            idle_code <= 4'd2;
          end else if (dnload_start) begin
            state     <= CHECK;
            cur_addr  <= BASE_ADDR + blk_addr;
            remaining <= dnload_len;
            offset    <= '0;
            blk       <= dnload_block;
          end
        end
        CHECK: begin
          if (abort) begin
            state <= IDLE; idle_code <= 4'd2;
          end else if ({1'b0, blk} >= MAX_B || remaining > XFER_SIZE) begin
            state <= ERROR; dfu_status <= 4'd8;
          end else if (cur_addr[SECTOR_BITS-1:0] == '0) begin
            state <= ERASE_REQ;
          end else begin
            state <= PROG_REQ;
          end
        end
        ADVANCE: begin
          cur_addr  <= cur_addr + ADDR_W'(chunk);
          offset    <= offset + XFER_BITS'(chunk);
          remaining <= rem_next;
          if (abort) begin
            state <= IDLE; idle_code <= 4'd2;
          end else if (rem_next == '0) begin
            state <= IDLE; idle_code <= 4'd5;
          end else begin
            state <= PROG_REQ;
          end
        end
        MANIFEST: state <= IDLE;
        ERROR: begin
          if (abort) begin
            state <= IDLE; idle_code <= 4'd2; dfu_status <= 4'd0;
          end
        end
        default: begin
          // Each *_WAIT encoding is its *_REQ plus one.
          if (is_req) begin
            if (flash_ack) begin
              state     <= state + 4'd1;
              done_pend <= flash_done;
              err_pend  <= flash_err;
              aborting  <= abort;
            end else if (abort) begin
              state <= IDLE; idle_code <= 4'd2;
            end
          end else if (is_wait) begin
            if (cmd_done) begin
              done_pend <= 1'b0;
              aborting  <= 1'b0;
              if (aborting || abort) begin
                state <= IDLE; idle_code <= 4'd2;
              end else if (cmd_err) begin
                state <= ERROR; dfu_status <= err_code;
              end else begin
                state <= ok_next;
              end
            end else if (abort) begin
              aborting <= 1'b1;
            end
          end else begin
            state <= IDLE;
          end
        end
      endcase
    end
  end

endmodule

// File: doc/usb_dfu_flash_seq.md
Name: usb_dfu_flash_seq

Overview:
- Sequences the SPI flash bridge for DFU downloads.
- Takes one received DNLOAD block, already held in the bridge's block buffer, and splits it into the flash operations it needs: a sector erase wherever a new sector is entered, then page programs.
- Tracks the DFU bState/bStatus values that the control endpoint reports in GETSTATUS.
- Sits between the DFU control endpoint logic and usb_spiflash_bridge, in the clk domain.

Parameters:
- ADDR_W, 24, flash byte-address width.
- BASE_ADDR, 24'h100000, flash address of DFU block 0.
- XFER_BITS, 8, log2 of wTransferSize; one block is at most 2^XFER_BITS bytes.
- PAGE_BITS, 8, log2 of the flash program page size. Must be <= XFER_BITS.
- SECTOR_BITS, 12, log2 of the flash erase sector size. Must be >= XFER_BITS.
- MAX_BLOCKS, 4096, number of accepted blocks; blocks >= MAX_BLOCKS are address errors.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- dnload_start  in  1  one-cycle pulse: a block is in the buffer.
- dnload_block  in  16  wBlockNum of the block.
- dnload_len  in  XFER_BITS+1  block length in bytes; 0 means end of download.
- abort  in  1  one-cycle pulse from DFU_ABORT or DFU_CLRSTATUS.
- busy  out  1  high while any flash operation is outstanding.
- dfu_state  out  4  DFU bState code.
- dfu_status  out  4  DFU bStatus code.
- flash_req  out  1  command request to the bridge.
- flash_cmd  out  2  01 = erase sector, 10 = program page, 11 = verify page.
- flash_addr  out  ADDR_W  flash byte address of the command.
- flash_len  out  PAGE_BITS+1  byte count for program/verify commands.
- buf_offset  out  XFER_BITS  offset into the block buffer for program/verify.
- flash_ack  in  1  bridge has accepted the command.
- flash_done  in  1  one-cycle pulse: the command has completed.
- flash_err  in  1  error flag, valid only when flash_done is high.

Behaviour:
- Reset values:
  - dfu_state = 2 (dfuIDLE), dfu_status = 0.
  - busy = 0, flash_req = 0, flash_cmd = 0, flash_addr = 0, flash_len = 0, buf_offset = 0.
- FSM states: IDLE, CHECK, ERASE_REQ, ERASE_WAIT, PROG_REQ, PROG_WAIT, [VERIFY_REQ, VERIFY_WAIT], ADVANCE, MANIFEST, ERROR.
- IDLE:
  - dnload_start with dnload_len = 0 -> MANIFEST.
  - dnload_start with dnload_len != 0 -> CHECK.
  - CHECK latches cur_addr = BASE_ADDR + (dnload_block << XFER_BITS), remaining = dnload_len, offset = 0.
- CHECK (one cycle), evaluated in this priority:
  - block >= MAX_BLOCKS or dnload_len > 2^XFER_BITS -> ERROR, status 8 (errADDRESS).
  - cur_addr[SECTOR_BITS-1:0] == 0 -> ERASE_REQ.
  - otherwise -> PROG_REQ.
- Request handshake:
  - flash_req rises with cmd/addr/len/offset stable; they are held until flash_ack is sampled high.
  - flash_req drops the cycle after ack; then go to the matching *_WAIT state.
  - flash_done arriving in the ack cycle is accepted.
- ERASE_WAIT on flash_done:
  - flash_err -> ERROR, status 4 (errERASE).
  - otherwise -> PROG_REQ.
- PROG_REQ chunk length:
  - len = min(remaining, 2^PAGE_BITS − cur_addr[PAGE_BITS-1:0]), so a program command never crosses a page boundary.
- PROG_WAIT on flash_done:
  - flash_err -> ERROR, status 6 (errPROG).
  - otherwise -> ADVANCE (or VERIFY_REQ, see Optional Feature).
- ADVANCE:
  - cur_addr += len, offset += len, remaining −= len.
  - remaining == 0 -> IDLE, dfu_state 5 (dfuDNLOAD_IDLE).
  - remaining != 0 -> PROG_REQ.
- MANIFEST:
  - dfu_state 7 for exactly 1 cycle, then IDLE with dfu_state 2.
- dfu_state mapping:
  - 4 (dfuDNBUSY) in CHECK through ADVANCE.
  - 10 (dfuERROR) in ERROR.
- busy is high in every state except IDLE and ERROR.
- ERROR:
  - Holds until abort; abort -> IDLE, dfu_state 2, dfu_status 0.
  - dnload_start in ERROR is ignored.
- abort while busy:
  - In a *_REQ state before ack: drop flash_req immediately, go to IDLE.
  - In a *_WAIT state: wait for flash_done (ignoring flash_err), then go to IDLE with status 0.
  - The bridge is never left with an orphan command.
- dnload_start while busy is ignored. The endpoint must poll GETSTATUS.
- Arithmetic:
  - cur_addr wraps modulo 2^ADDR_W with no error.
  - All length math uses PAGE_BITS+1 bits.
- Simultaneous abort and flash_done in a WAIT state: go to IDLE, status 0.

Optional Feature:
- Macro: USB_DFU_VERIFY_EN.
- Defined:
  - After each successful program, issue cmd 11 (verify page) with the same addr/len/offset; it uses the same handshake.
  - flash_err on its flash_done -> ERROR, status 7 (errVERIFY).
  - Otherwise -> ADVANCE.
- Undefined:
  - The VERIFY states and cmd 11 do not exist; PROG_WAIT goes directly to ADVANCE.

Test Plan:
- Block 0, len 256, defaults -> erase @0x100000, then one program @0x100000 len 256 offset 0; dfu_state 4 then 5; busy low afterwards.
- Block 1, len 256 -> no erase; one program @0x100100 len 256.
- PAGE_BITS=7, block 2, len 200 -> programs @0x100200 len 128 off 0, then @0x100280 len 72 off 128; no erase.
- Erase completes with flash_err=1 -> dfu_state 10, dfu_status 4, busy 0; next dnload_start ignored; abort -> state 2, status 0.
- Abort during PROG_WAIT, flash_done 5 cycles later -> flash_req stays 0 and no new command is issued; IDLE, status 0 after done.
- Block 4096 -> ERROR, status 8, no flash_req. Then abort, then dnload_len 0 -> dfu_state 7 for 1 cycle, then 2.
